instruction_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the Harvard machine.
- Drives the program-ROM address and captures the 22-bit instruction word {opcode[4:0], addressing mode, operand[15:0]}.
- Strobes the decoder stage, and for memory-addressed operands runs a data-memory read handshake before execute.
- Owns the program counter, including branch redirection from the execute unit and HALT detection.

---
 rtl/harvard_pkg.sv | 27 ++
 rtl/program_counter.sv | 33 +++
 rtl/instruction_sequencer.sv | 131 +++++++++++++
 tb/tb_instruction_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/harvard_pkg.sv
// rtl/harvard_pkg.sv - shared types and instruction field layout for the Harvard sequencer
//
// Purpose: sequencer state encoding, 22-bit instruction word field positions
//          and the default HALT opcode. Imported by the sequencer and its tests.
// Ports:   none (package).
package harvard_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_OPERAND = 3'd3,
      ST_EXECUTE = 3'd4,
      ST_HALT    = 3'd5
   } seq_state_t;

   // Instruction word: {opcode[21:17], mode[16], operand[15:0]}
   localparam int INSTR_WIDTH   = 22;
   localparam int OPCODE_WIDTH  = 5;
   localparam int OPCODE_LSB    = 17;
   localparam int MODE_BIT      = 16;
   localparam int OPERAND_WIDTH = 16;
   localparam int OPERAND_LSB   = 0;

   localparam logic [OPCODE_WIDTH-1:0] DEFAULT_HALT_OPCODE = 5'b11111;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with branch load, wrapping increment and hold
//
// Purpose: holds the ROM address of the current instruction.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset, clears the count
//   load       in   replace the count with target (takes priority over increment)
//   increment  in   advance by one, wrapping modulo 2^WIDTH
//   target     in   WIDTH  load value
//   value      out  WIDTH  current program counter
module program_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             increment,
   input  logic [WIDTH-1:0] target,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= target;
      end else if (increment) begin
         // Natural overflow of the WIDTH-bit add gives the max -> 0 wrap.
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/decode/operand/execute controller for the Harvard machine
//
// Purpose: walks each instruction through FETCH, DECODE, optional OPERAND
//          (data-memory read) and EXECUTE, owns the PC and stops on HALT.
//          Every output comes from a register; no input reaches an output
//          combinationally.
// Ports:
//   ClockInput             in   clock, rising edge
//   ResetInput             in   synchronous active-high reset
//   RunInput               in   1 = run, 0 = pause at the next instruction boundary
//   InstructionInput       in   22  ROM data, valid the cycle after the address
//   DataReadyInput         in   data-memory read complete (OPERAND only)
//   BranchTakenInput       in   redirect request (EXECUTE only)
//   BranchTargetInput      in   PC_WIDTH  redirect address
//   ProgramAddressOutput   out  PC_WIDTH  ROM address (= PC)
//   FetchEnableOutput      out  ROM read enable
//   OpecodeOutput          out  5   instruction register opcode
//   AddressingModeOutput   out  instruction register mode bit
//   OperandOutput          out  16  instruction register operand
//   DecodeStrobeOutput     out  one-cycle decoder latch pulse
//   DataReadRequestOutput  out  data-memory read request
//   DataAddressOutput      out  16  data-memory address (= operand)
//   ExecuteStrobeOutput    out  one-cycle execute enable
//   HaltedOutput           out  stopped on HALT
//   StateOutput            out  3   current state encoding
module instruction_sequencer
   import harvard_pkg::*;
#(
   parameter int                      PC_WIDTH    = 8,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
   input  logic                     ClockInput,
   input  logic                     ResetInput,
   input  logic                     RunInput,
   input  logic [INSTR_WIDTH-1:0]   InstructionInput,
   input  logic                     DataReadyInput,
   input  logic                     BranchTakenInput,
   input  logic [PC_WIDTH-1:0]      BranchTargetInput,
   output logic [PC_WIDTH-1:0]      ProgramAddressOutput,
   output logic                     FetchEnableOutput,
   output logic [OPCODE_WIDTH-1:0]  OpecodeOutput,
   output logic                     AddressingModeOutput,
   output logic [OPERAND_WIDTH-1:0] OperandOutput,
   output logic                     DecodeStrobeOutput,
   output logic                     DataReadRequestOutput,
   output logic [OPERAND_WIDTH-1:0] DataAddressOutput,
   output logic                     ExecuteStrobeOutput,
   output logic                     HaltedOutput,
   output logic [2:0]               StateOutput
);

   seq_state_t             state;
   seq_state_t             next_state;
   logic [INSTR_WIDTH-1:0] ir;
   logic                   pc_load;
   logic                   pc_increment;

   logic [OPCODE_WIDTH-1:0] incoming_opcode;
   logic                    incoming_mode;

   assign incoming_opcode = InstructionInput[OPCODE_LSB +: OPCODE_WIDTH];
   assign incoming_mode   = InstructionInput[MODE_BIT];

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    next_state = RunInput ? ST_FETCH : ST_IDLE;
         ST_FETCH:   next_state = ST_DECODE;
         ST_DECODE: begin
            // Routed from the word arriving now, not from the IR it is about to fill.
            if (incoming_opcode == HALT_OPCODE) begin
               next_state = ST_HALT;
            end else if (incoming_mode) begin
               next_state = ST_OPERAND;
            end else begin
               next_state = ST_EXECUTE;
            end
         end
         ST_OPERAND: next_state = DataReadyInput ? ST_EXECUTE : ST_OPERAND;
         ST_EXECUTE: next_state = RunInput ? ST_FETCH : ST_IDLE;
         ST_HALT:    next_state = ST_HALT;
         default:    next_state = ST_IDLE;
      endcase
   end

   // Outputs are registered from next_state so each is high exactly while the
   // FSM sits in its owning state.
   always_ff @(posedge ClockInput) begin
      if (ResetInput) begin
         state                 <= ST_IDLE;
         ir                    <= '0;
         FetchEnableOutput     <= 1'b0;
         DecodeStrobeOutput    <= 1'b0;
         DataReadRequestOutput <= 1'b0;
         ExecuteStrobeOutput   <= 1'b0;
         HaltedOutput          <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_DECODE) begin
            ir <= InstructionInput;
         end
         FetchEnableOutput     <= (next_state == ST_FETCH);
         // Pulse in the first cycle after DECODE; a HALT word is never decoded.
         DecodeStrobeOutput    <= (state == ST_DECODE) && (next_state != ST_HALT);
         DataReadRequestOutput <= (next_state == ST_OPERAND);
         ExecuteStrobeOutput   <= (next_state == ST_EXECUTE);
         HaltedOutput          <= (next_state == ST_HALT);
      end
   end

   assign pc_load      = (state == ST_EXECUTE) &&  BranchTakenInput;
   assign pc_increment = (state == ST_EXECUTE) && !BranchTakenInput;

   program_counter #(
      .WIDTH (PC_WIDTH)
   ) u_program_counter (
      .clk       (ClockInput),
      .reset     (ResetInput),
      .load      (pc_load),
      .increment (pc_increment),
      .target    (BranchTargetInput),
      .value     (ProgramAddressOutput)
   );

   assign OpecodeOutput        = ir[OPCODE_LSB +: OPCODE_WIDTH];
   assign AddressingModeOutput = ir[MODE_BIT];
   assign OperandOutput        = ir[OPERAND_LSB +: OPERAND_WIDTH];
   assign DataAddressOutput    = ir[OPERAND_LSB +: OPERAND_WIDTH];
   assign StateOutput          = state;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [21:0] instr = '0;
   logic        rdy = 1'b0;
   logic        br = 1'b0;
   logic [7:0]  tgt = '0;

   logic [7:0]  addr;
   logic        fetch_en;
   logic [4:0]  opcode;
   logic        mode;
   logic [15:0] operand;
   logic        dec_stb;
   logic        rd_req;
   logic [15:0] daddr;
   logic        exe_stb;
   logic        halted;
   logic [2:0]  state;

   instruction_sequencer #(.PC_WIDTH(8), .HALT_OPCODE(5'b11111)) dut (
      .ClockInput            (clk),
      .ResetInput            (rst),
      .RunInput              (run),
      .InstructionInput      (instr),
      .DataReadyInput        (rdy),
      .BranchTakenInput      (br),
      .BranchTargetInput     (tgt),
      .ProgramAddressOutput  (addr),
      .FetchEnableOutput     (fetch_en),
      .OpecodeOutput         (opcode),
      .AddressingModeOutput  (mode),
      .OperandOutput         (operand),
      .DecodeStrobeOutput    (dec_stb),
      .DataReadRequestOutput (rd_req),
      .DataAddressOutput     (daddr),
      .ExecuteStrobeOutput   (exe_stb),
      .HaltedOutput          (halted),
      .StateOutput           (state)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          m_pc;
   logic [21:0] m_ir;
   logic [31:0] trace_code;
   logic        was_halted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble();
      rdy   = 1'($urandom());
      br    = 1'($urandom());
      tgt   = 8'($urandom());
      instr = 22'($urandom());
   endtask

   // Expected view of one cycle: state code plus strobes; PC and IR from the model.
   task automatic expect_cycle(input logic [2:0] st, input logic fe, input logic ds,
                               input logic rr, input logic es, input logic hl);
      trace_code = (trace_code << 3) | 32'(st);
      chk("state",    32'(state),    32'(st));
      chk("fetch_en", 32'(fetch_en), 32'(fe));
      chk("addr",     32'(addr),     32'(m_pc));
      chk("dec_stb",  32'(dec_stb),  32'(ds));
      chk("rd_req",   32'(rd_req),   32'(rr));
      chk("exe_stb",  32'(exe_stb),  32'(es));
      chk("halted",   32'(halted),   32'(hl));
      chk("opcode",   32'(opcode),   32'(m_ir[21:17]));
      chk("mode",     32'(mode),     32'(m_ir[16]));
      chk("operand",  32'(operand),  32'(m_ir[15:0]));
      chk("daddr",    32'(daddr),    32'(m_ir[15:0]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'($urandom());
      scramble();
      tick();
      m_pc = 0;
      m_ir = '0;
      expect_cycle(3'd0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      run = 1'b1;
   endtask

   // One whole instruction, starting with the next edge landing in FETCH.
   // waits: OPERAND cycles before the ready one. abort: OPERAND cycle index in
   // which reset is applied instead (-1 = none).
   task automatic run_instr(input logic [21:0] word, input int waits, input logic branch,
                            input logic [7:0] target, input logic run_after, input int gap,
                            input int abort, output logic halted_out);
      halted_out = 1'b0;
      tick();
      expect_cycle(3'd1, 1, 0, 0, 0, 0);
      scramble();
      run = 1'($urandom());
      tick();
      expect_cycle(3'd2, 0, 0, 0, 0, 0);
      scramble();
      run   = 1'($urandom());
      instr = word;
      tick();
      m_ir = word;
      if (word[21:17] == 5'b11111) begin
         expect_cycle(3'd5, 0, 0, 0, 0, 1);
         halted_out = 1'b1;
         return;
      end
      if (word[16]) begin
         for (int i = 0; i <= waits; i++) begin
            if (i > 0) tick();
            expect_cycle(3'd3, 0, (i == 0), 1, 0, 0);
            scramble();
            run = 1'($urandom());
            if (i == abort) begin
               rst = 1'b1;
               tick();
               m_pc = 0;
               m_ir = '0;
               expect_cycle(3'd0, 0, 0, 0, 0, 0);
               rst = 1'b0;
               run = 1'b1;
               return;
            end
            rdy = (i == waits);
         end
         tick();
      end
      expect_cycle(3'd4, 0, !word[16], 0, 1, 0);
      scramble();
      br  = branch;
      tgt = target;
      run = run_after;
      m_pc = branch ? int'(target) : (m_pc + 1) % 256;
      if (!run_after) begin
         for (int k = 0; k < gap; k++) begin
            tick();
            expect_cycle(3'd0, 0, 0, 0, 0, 0);
            scramble();
            run = (k == gap - 1);
         end
      end
   endtask

   task automatic halt_hold(input int n);
      for (int i = 0; i < n; i++) begin
         scramble();
         run = 1'($urandom());
         tick();
         expect_cycle(3'd5, 0, 0, 0, 0, 1);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      m_pc = 0;
      m_ir = '0;
      trace_code = '0;
      do_reset();

      // Register-mode: FETCH, DECODE, EXECUTE
      trace_code = '0;
      run_instr({5'b00011, 1'b0, 16'h0042}, 0, 0, 8'h00, 1, 1, -1, was_halted);
      chk("t1_trace", trace_code, 32'o124);
      chk("t1_operand", 32'(operand), 32'h0042);
      chk("t1_model_pc", 32'(m_pc), 32'd1);

      // Memory-mode with three OPERAND cycles, then zero-wait
      trace_code = '0;
      run_instr({5'b00100, 1'b1, 16'h1234}, 2, 0, 8'h00, 1, 1, -1, was_halted);
      chk("t2_trace_wait", trace_code, 32'o123334);
      chk("t2_daddr", 32'(daddr), 32'h1234);
      trace_code = '0;
      run_instr({5'b00101, 1'b1, 16'h0777}, 0, 0, 8'h00, 1, 1, -1, was_halted);
      chk("t2_trace_nowait", trace_code, 32'o1234);

      // Branch redirect, then wrap from 0xFF
      run_instr({5'b00110, 1'b0, 16'h0001}, 0, 1, 8'h05, 1, 1, -1, was_halted);
      chk("t3_model_pc", 32'(m_pc), 32'd5);
      run_instr({5'b00110, 1'b0, 16'h0002}, 0, 1, 8'hFF, 1, 1, -1, was_halted);
      run_instr({5'b00001, 1'b0, 16'h0003}, 0, 0, 8'h00, 1, 1, -1, was_halted);
      chk("t4_model_pc_wrap", 32'(m_pc), 32'd0);

      // Run dropped in EXECUTE: three IDLE cycles before resuming
      trace_code = '0;
      run_instr({5'b00010, 1'b0, 16'h00AA}, 0, 0, 8'h00, 0, 3, -1, was_halted);
      chk("t6_trace_pause", trace_code, 32'o124000);

      // Reset while waiting on data memory
      run_instr({5'b00001, 1'b0, 16'h0004}, 0, 0, 8'h00, 1, 1, -1, was_halted);
      trace_code = '0;
      run_instr({5'b01000, 1'b1, 16'h5555}, 5, 0, 8'h00, 1, 1, 2, was_halted);
      chk("t6_trace_abort", trace_code, 32'o123330);
      chk("t6_addr_after_reset", 32'(addr), 32'd0);

      // HALT: no execute, PC frozen, run ignored
      run_instr({5'b00001, 1'b0, 16'h0005}, 0, 0, 8'h00, 1, 1, -1, was_halted);
      trace_code = '0;
      run_instr({5'b11111, 1'b0, 16'hBEEF}, 0, 0, 8'h00, 1, 1, -1, was_halted);
      chk("t5_trace", trace_code, 32'o125);
      chk("t5_halted_flag", 32'(was_halted), 32'd1);
      halt_hold(6);
      chk("t5_addr_frozen", 32'(addr), 32'd1);
      do_reset();

      // Randomized episodes
      for (int ep = 0; ep < 25; ep++) begin
         do_reset();
         for (int n = 0; n < 40; n++) begin
            logic [21:0] w;
            int          waits;
            int          abort;
            w     = 22'($urandom());
            waits = int'($urandom_range(0, 3));
            abort = -1;
            if (w[16] && waits > 0 && $urandom_range(0, 9) == 0)
               abort = int'($urandom_range(0, waits));
            run_instr(w, waits, ($urandom_range(0, 3) == 0), 8'($urandom()),
                      ($urandom_range(0, 2) != 0), int'($urandom_range(1, 3)), abort,
                      was_halted);
            if (was_halted) begin
               halt_hold(int'($urandom_range(3, 6)));
               break;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
